// File: rtl/port_arbiter_pkg.sv
// Shared types and constants for the port_arbiter block.
package port_arbiter_pkg;

  typedef logic [31:0] pkt_t;

  localparam int BYTES_PER_PKT = 4;

  typedef enum logic {
    IDLE,
    SEND
  } arb_state_t;

endpackage

// File: rtl/port_arbiter_rr_pick.sv
// rr_pick: combinational winner selection (round-robin from i_ptr, or fixed
// priority when ARB_FIXED_PRIORITY_EN is defined).
module rr_pick
  import port_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_idx
);

`ifdef ARB_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^i_ptr;

  // Scanning downward lets the lowest requesting index overwrite the rest.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_idx      = IDW'(i);
      end
    end
  end
`else
  // Offset k from the pointer; smallest k wins, so scan offsets downward.
  always_comb begin
    int w_pos;
    o_grant = '0;
    o_idx   = '0;
    w_pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = (int'(i_ptr) + k) % N;
      if (i_req[w_pos]) begin
        o_grant        = '0;
        o_grant[w_pos] = 1'b1;
        o_idx          = IDW'(w_pos);
      end
    end
  end
`endif

endmodule

// File: rtl/port_arbiter.sv
// port_arbiter: pops one packet at a time from NUM_REQ queues and serializes it
// MSB-first onto an 8-bit link. Define ARB_FIXED_PRIORITY_EN for fixed priority.
module port_arbiter
  import port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  pkt_t [NUM_REQ-1:0]       q_data,
  input  logic [NUM_REQ-1:0]       q_empty,
  output logic [NUM_REQ-1:0]       q_re,
  input  logic                     free_outbound,
  output logic                     put_outbound,
  output logic [7:0]               payload_outbound,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id
);

  localparam logic [1:0] LAST_CNT = 2'(BYTES_PER_PKT - 1);

  arb_state_t         r_state, w_state_next;
  logic [1:0]         r_cnt, w_cnt_next;
  pkt_t               r_shreg, w_shreg_next;
  logic [IDW-1:0]     r_grant_id, w_grant_id_next;
  logic [NUM_REQ-1:0] w_req, w_grant;
  logic [IDW-1:0]     w_idx, w_ptr;
  logic               w_start;

  assign w_req = ~q_empty;
  // No pop while reset is held, so a queue is not drained into a cleared register.
  assign w_start = (r_state == IDLE) && free_outbound && (|w_req) && !reset;

  rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
    .i_req   (w_req),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

`ifdef ARB_FIXED_PRIORITY_EN
  assign w_ptr = '0;
`else
  logic [IDW-1:0] r_ptr, w_ptr_next;
  assign w_ptr = r_ptr;

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_start) begin
      w_ptr_next = (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_ptr <= '0;
    else       r_ptr <= w_ptr_next;
  end
`endif

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_shreg_next    = r_shreg;
    w_grant_id_next = r_grant_id;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_next    = SEND;
          w_cnt_next      = '0;
          w_shreg_next    = q_data[w_idx];
          w_grant_id_next = w_idx;
        end
      end
      SEND: begin
        w_shreg_next = {r_shreg[23:0], 8'h00};
        w_cnt_next   = r_cnt + 2'd1;
        if (r_cnt == LAST_CNT) begin
          w_state_next    = IDLE;
          w_grant_id_next = '0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_grant_id <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_shreg    <= w_shreg_next;
      r_grant_id <= w_grant_id_next;
    end
  end

  assign q_re             = w_start ? w_grant : '0;
  assign put_outbound     = (r_state == SEND);
  assign payload_outbound = put_outbound ? r_shreg[31:24] : 8'h00;
  assign busy             = put_outbound;
  assign grant_id         = r_grant_id;

endmodule

// File: tb/tb_port_arbiter.sv
// Scoreboard bench for port_arbiter: stimulus queues expected pops and bytes,
// a negedge monitor pops and compares whenever the DUT pops or puts a byte.
module tb_port_arbiter;
  import port_arbiter_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  pkt_t [N-1:0]   q_data;
  logic [N-1:0]   q_empty;
  logic [N-1:0]   q_re;
  logic           free;
  logic           put;
  logic [7:0]     payload;
  logic           busy;
  logic [1:0]     gid;

  always #5 clk = ~clk;

  port_arbiter #(.NUM_REQ(N)) dut (
    .clock            (clk),
    .reset            (rst),
    .q_data           (q_data),
    .q_empty          (q_empty),
    .q_re             (q_re),
    .free_outbound    (free),
    .put_outbound     (put),
    .payload_outbound (payload),
    .busy             (busy),
    .grant_id         (gid)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
  } byte_exp_t;

  byte_exp_t  exp_bytes[$];
  logic [N-1:0] exp_re[$];
  int         re_cycles[$];
  pkt_t       fifo[N][$];
  logic [N-1:0] last_re = '0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  byte_exp_t  mon_e;
  logic [N-1:0] mon_re;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      q_empty[i] = (fifo[i].size() == 0);
      q_data[i]  = q_empty[i] ? 32'h0 : fifo[i][0];
    end
  endtask

  // Advance one cycle; apply the pop the DUT performed in the previous cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (last_re[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
    refresh();
    #1;
  endtask

  task automatic expect_pkt(int q, pkt_t p);
    logic [N-1:0] oh;
    byte_exp_t e;
    oh = '0;
    oh[q] = 1'b1;
    exp_re.push_back(oh);
    for (int k = 3; k >= 0; k--) begin
      e.data = p[8*k +: 8];
      e.id   = 2'(q);
      exp_bytes.push_back(e);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    last_re = q_re;
    if (q_re !== '0) begin
      re_cycles.push_back(cyc);
      $display("cycle %0d pop q_re=%b", cyc, q_re);
      if (exp_re.size() == 0) check("unexpected q_re", 32'(q_re), 32'h0);
      else begin
        mon_re = exp_re.pop_front();
        check("q_re", 32'(q_re), 32'(mon_re));
      end
    end
    if (put === 1'b1) begin
      $display("cycle %0d byte %h grant_id %0d", cyc, payload, gid);
      if (exp_bytes.size() == 0) check("unexpected put", 32'(put), 32'h0);
      else begin
        mon_e = exp_bytes.pop_front();
        check("payload", 32'(payload), 32'(mon_e.data));
        check("grant_id", 32'(gid), 32'(mon_e.id));
        check("busy", 32'(busy), 32'h1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    free = 1'b0;
    refresh();
    repeat (3) tick();
    check("reset put", 32'(put), 32'h0);
    check("reset payload", 32'(payload), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset grant_id", 32'(gid), 32'h0);
    check("reset q_re", 32'(q_re), 32'h0);
    rst = 1'b0;
    tick();

    // Single packet from queue 2.
    fifo[2].push_back(32'hDEADBEEF);
    expect_pkt(2, 32'hDEADBEEF);
    free = 1'b1;
    refresh();
    #1;
    check("single q_re", 32'(q_re), 32'h4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("single put", 32'(put), 32'h1);
      check("single q_re quiet", 32'(q_re), 32'h0);
    end
    tick();
    check("single back idle", 32'(busy), 32'h0);

    // Wrap and skip: ptr is 3, only queue 1 pending -> 1, then ptr=2.
    fifo[1].push_back(32'h11223344);
    expect_pkt(1, 32'h11223344);
    refresh();
    #1;
    check("wrap q_re", 32'(q_re), 32'h2);
    repeat (5) tick();
    fifo[0].push_back(32'hA0A1A2A3);
    fifo[2].push_back(32'hC0C1C2C3);
    expect_pkt(2, 32'hC0C1C2C3);
    expect_pkt(0, 32'hA0A1A2A3);
    refresh();
    #1;
    check("skip q_re", 32'(q_re), 32'h4);
    repeat (10) tick();

    // Fairness after reset: 0,1,2,3,0 at a 5-cycle period.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    re_cycles.delete();
    fifo[0].push_back(32'h00000001);
    fifo[1].push_back(32'h10101010);
    fifo[2].push_back(32'h20202020);
    fifo[3].push_back(32'h30303030);
    fifo[0].push_back(32'h0A0B0C0D);
    expect_pkt(0, 32'h00000001);
    expect_pkt(1, 32'h10101010);
    expect_pkt(2, 32'h20202020);
    expect_pkt(3, 32'h30303030);
    expect_pkt(0, 32'h0A0B0C0D);
    refresh();
    repeat (26) tick();
    check("fair grant count", 32'(re_cycles.size()), 32'd5);
    for (int k = 0; k + 1 < re_cycles.size(); k++)
      check("fair spacing", 32'(re_cycles[k+1] - re_cycles[k]), 32'd5);

    // Backpressure: no pop while free is low, pop in the cycle it rises.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    free = 1'b0;
    fifo[0].push_back(32'h55667788);
    expect_pkt(0, 32'h55667788);
    refresh();
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp idle", 32'({q_re, put}), 32'h0);
    end
    free = 1'b1;
    #1;
    check("bp q_re", 32'(q_re), 32'h1);
    tick();
    check("bp first put", 32'(put), 32'h1);
    check("bp first byte", 32'(payload), 32'h55);
    repeat (4) tick();

    // free drops during SEND: all four bytes still go out back to back.
    fifo[2].push_back(32'hCAFEF00D);
    expect_pkt(2, 32'hCAFEF00D);
    refresh();
    #1;
    check("drop q_re", 32'(q_re), 32'h4);
    tick();
    free = 1'b0;
    check("drop put", 32'(put), 32'h1);
    repeat (3) begin
      tick();
      check("drop put", 32'(put), 32'h1);
    end
    tick();
    check("drop end", 32'(put), 32'h0);
    free = 1'b1;

    // Reset during the second byte.
    fifo[3].push_back(32'hA1B2C3D4);
    exp_re.push_back(4'b1000);
    exp_bytes.push_back('{data: 8'hA1, id: 2'd3});
    exp_bytes.push_back('{data: 8'hB2, id: 2'd3});
    refresh();
    #1;
    check("rst q_re", 32'(q_re), 32'h8);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst put", 32'(put), 32'h0);
    check("rst payload", 32'(payload), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst grant_id", 32'(gid), 32'h0);
    rst = 1'b0;
    tick();
    fifo[1].push_back(32'h0F1E2D3C);
    fifo[0].push_back(32'h01020304);
    expect_pkt(0, 32'h01020304);
    expect_pkt(1, 32'h0F1E2D3C);
    refresh();
    #1;
    check("post-rst q_re", 32'(q_re), 32'h1);
    repeat (11) tick();

    check("leftover pops", 32'(exp_re.size()), 32'h0);
    check("leftover bytes", 32'(exp_bytes.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/port_arbiter.md
# port_arbiter

Shares one router outbound byte link between NUM_REQ packet queues (the 4-deep node/router FIFOs). Each cycle the arbiter is idle, it picks one non-empty queue, pops a 32-bit packet and serializes it onto the 8-bit put/free link as four bytes, MSB first. It sits between a router's per-input queues and one output port, and it is the only block that drives that port's put/payload pair.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting queues; legal range 2..8.
- IDW, $clog2(NUM_REQ), width of grant_id (derived; do not override).

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- q_data  input  NUM_REQ x pkt_t (32 each)  head-of-queue packet per requester; valid when matching q_empty is low.
- q_empty  input  NUM_REQ  queue empty flags.
- q_re  output  NUM_REQ  one-hot pop strobe; at most one bit high, for exactly one cycle per packet.
- free_outbound  input  1  downstream can accept a packet.
- put_outbound  output  1  a byte is on payload_outbound this cycle.
- payload_outbound  output  8  serialized packet byte.
- busy  output  1  a packet is being serialized.
- grant_id  output  IDW  index of the queue being served; valid while busy, 0 otherwise.

## Operation
- FSM states: IDLE, SEND. A 2-bit byte counter cnt is used in SEND.
- IDLE: if free_outbound=1 and any q_empty bit is 0, choose a winner w. Drive q_re[w]=1 combinationally in the same cycle. At the clock edge, load q_data[w] into a 32-bit shift register, set grant_id=w, cnt=0, and go to SEND. Otherwise stay in IDLE with q_re=0.
- SEND: drive put_outbound=1 and payload_outbound=shreg[31:24]. Each edge, shift shreg left by 8 and increment cnt. When cnt==3, return to IDLE.
- SEND ignores free_outbound and q_empty. A packet is never split or aborted except by reset.
- Round-robin (default): pointer ptr starts at 0. The winner is the first non-empty index at or above ptr, wrapping from NUM_REQ-1 to 0. After a grant to w, ptr = (w+1) mod NUM_REQ. ptr is unchanged when no grant occurs.
- Outputs in IDLE: put_outbound=0, payload_outbound=0, busy=0, grant_id=0.
- Reset (any state): go to IDLE with ptr=0, cnt=0, shreg=0, and all outputs 0. Reset mid-SEND drops the remaining bytes; the popped packet is lost. This is intended.

## Timing
- Request present and free_outbound high in cycle T: q_re pulses in T, put_outbound is high for T+1..T+4 with bytes [31:24], [23:16], [15:8], [7:0], and the block is back in IDLE at T+5.
- The earliest next q_re is in T+5, so there is one idle link cycle between packets (fixed, 5-cycle packet period).
- A queue that becomes non-empty in cycle T is eligible in T. Its q_empty is combinational into the winner selection.
- When free_outbound and a non-empty queue occur in the same cycle, the grant happens that cycle. free_outbound is sampled only in IDLE.
- Reset asserted in cycle T: all outputs are 0 from T+1.

## Configuration
- ARB_FIXED_PRIORITY_EN:
  - Defined: fixed priority, lowest non-empty index wins. ptr is removed and has no effect.
  - Undefined (default): round-robin as above.
- All other behaviour and timing are identical in both builds.

## Structure
- Shared package: pkt_t (32-bit packet typedef), BYTES_PER_PKT=4, and the arb_state_t enum {IDLE, SEND}.
- One sub-module, rr_pick: combinational. Inputs are a request vector and ptr; outputs are a one-hot grant and its encoded index. Under ARB_FIXED_PRIORITY_EN it reduces to a priority encoder.
- FSM, counter, shift register and ptr live in port_arbiter.

## Test plan
- Single packet: queue 2 holds 32'hDEADBEEF, free_outbound=1 -> q_re=4'b0100 for one cycle; then put=1 for 4 cycles with bytes DE, AD, BE, EF; grant_id=2, busy=1 over those cycles.
- Round-robin fairness: all 4 queues non-empty and free held high -> grant order 0,1,2,3,0. Each grant is 5 cycles apart and each q_re is one cycle wide.
- Backpressure: queue 0 non-empty, free_outbound=0 for 10 cycles -> no q_re and put=0 throughout. Raising free in cycle T -> q_re in T and the first byte in T+1.
- Wrap and skip: ptr=3 with only queue 1 non-empty -> grant 1, then ptr=2. With ARB_FIXED_PRIORITY_EN defined, queues 1 and 3 non-empty -> 1 is always granted while 1 stays non-empty.
- Reset mid-packet: reset during the 2nd byte -> put, payload, busy and grant_id are all 0 the next cycle. The next packet restarts at byte 0 and ptr=0.
- free_outbound dropping during SEND -> all 4 bytes are still sent on consecutive cycles.
